wdt_reset_ctrl: RTL and testbench

Downstream consumer of the watchdog timer's timeout output. Converts a watchdog trip or a software reset request into a fixed-width system reset pulse, and kicks the watchdog so it restarts. Ignores re-trips during a post-reset grace window. After MAX_RESETS unacknowledged watchdog trips it escalates to a latched fault lockout that holds the system in reset until software clears it.

---
 rtl/wdt_pkg.sv | 22 ++
 rtl/wdt_edge_det.sv | 19 +
 rtl/wdt_reset_ctrl.sv | 129 ++++++++++++
 tb/tb_wdt_reset_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog reset controller: FSM state encoding,
// cause codes and a counter-width helper.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GRACE  = 2'd2,
      LOCKED = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_WDT  = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;
   localparam logic [1:0] CAUSE_LOCK = 2'b11;

   // Width of a counter running 0..n-1; a limit of 1 still needs one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wdt_edge_det.sv
// Registered rising-edge detector; a held high level produces a single event.
module wdt_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic q;

   // Previous-cycle sample of the input, updated every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog / software reset controller. Turns a watchdog trip or software
// request into a PULSE_LEN-cycle system reset, kicks the watchdog, ignores
// requests for GRACE_LEN cycles afterwards and locks out after MAX_RESETS
// unacknowledged trips.
// Optional build macro: WDT_CAUSE_EN adds the cause_o reporting port.
module wdt_reset_ctrl
   import wdt_pkg::*;
#(
   parameter int PULSE_LEN  = 16,
   parameter int GRACE_LEN  = 64,
   parameter int MAX_RESETS = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wdt_trip_i,
   input  logic                            sw_rst_req_i,
   input  logic                            clr_i,
   output logic                            sys_rst_o,
   output logic                            wdt_kick_o,
   output logic                            fault_o,
   output logic [$clog2(MAX_RESETS+1)-1:0] reset_cnt_o
`ifdef WDT_CAUSE_EN
   ,
   output logic [1:0]                      cause_o
`endif
);

   localparam int PW = cnt_w(PULSE_LEN);
   localparam int GW = cnt_w(GRACE_LEN);
   localparam int RW = $clog2(MAX_RESETS + 1);

   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
   localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_LEN - 1);
   localparam logic [RW-1:0] CNT_MAX    = RW'(MAX_RESETS);
   localparam logic [RW-1:0] CNT_LOCK   = RW'(MAX_RESETS - 1);

   state_e        state;
   logic [PW-1:0] pulse_cnt;
   logic [GW-1:0] grace_cnt;
   logic [RW-1:0] reset_cnt;
   logic          trip_evt;
`ifdef WDT_CAUSE_EN
   logic [1:0]    cause;
`endif

   wdt_edge_det u_trip_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (wdt_trip_i),
      .rise  (trip_evt)
   );

   // Reset sequencing FSM with its pulse/grace timers and trip counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         grace_cnt <= '0;
         reset_cnt <= '0;
`ifdef WDT_CAUSE_EN
         cause     <= CAUSE_NONE;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (trip_evt) begin
                  // Saturate so the count can never wrap past MAX_RESETS.
                  if (reset_cnt != CNT_MAX) reset_cnt <= reset_cnt + RW'(1);
                  if (reset_cnt >= CNT_LOCK) begin
                     state <= LOCKED;
`ifdef WDT_CAUSE_EN
                     cause <= CAUSE_LOCK;
`endif
                  end else begin
                     state     <= ASSERT;
                     pulse_cnt <= '0;
`ifdef WDT_CAUSE_EN
                     cause     <= CAUSE_WDT;
`endif
                  end
               end else if (sw_rst_req_i) begin
                  state     <= ASSERT;
                  pulse_cnt <= '0;
`ifdef WDT_CAUSE_EN
                  cause     <= CAUSE_SW;
`endif
               end else if (clr_i) begin
                  reset_cnt <= '0;
`ifdef WDT_CAUSE_EN
                  cause     <= CAUSE_NONE;
`endif
               end
            end
            ASSERT: begin
               if (pulse_cnt == PULSE_LAST) begin
                  state     <= GRACE;
                  grace_cnt <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + PW'(1);
               end
            end
            GRACE: begin
               if (grace_cnt == GRACE_LAST) state <= IDLE;
               else                         grace_cnt <= grace_cnt + GW'(1);
            end
            LOCKED: begin
               // Only a software clear releases the lockout.
               if (clr_i) begin
                  state     <= IDLE;
                  reset_cnt <= '0;
`ifdef WDT_CAUSE_EN
                  cause     <= CAUSE_NONE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sys_rst_o   = (state == ASSERT) || (state == LOCKED);
   assign wdt_kick_o  = (state == ASSERT) || (state == LOCKED);
   assign fault_o     = (state == LOCKED);
   assign reset_cnt_o = reset_cnt;
`ifdef WDT_CAUSE_EN
   assign cause_o     = cause;
`endif

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Self-checking bench for wdt_reset_ctrl: timestamp-based reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_wdt_reset_ctrl;

   localparam int P     = 16;
   localparam int G     = 64;
   localparam int MAXR  = 3;
   localparam int RW    = $clog2(MAXR + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trip = 1'b0;
   logic          sw = 1'b0;
   logic          clr = 1'b0;
   logic          sys_rst, kick, fault;
   logic [RW-1:0] cnt;
`ifdef WDT_CAUSE_EN
   logic [1:0]    cause;
`endif

   wdt_reset_ctrl #(.PULSE_LEN(P), .GRACE_LEN(G), .MAX_RESETS(MAXR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wdt_trip_i   (trip),
      .sw_rst_req_i (sw),
      .clr_i        (clr),
      .sys_rst_o    (sys_rst),
      .wdt_kick_o   (kick),
      .fault_o      (fault),
      .reset_cnt_o  (cnt)
`ifdef WDT_CAUSE_EN
      ,
      .cause_o      (cause)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Reference model: time-stamp based. k is the index of the next edge.
   int k = 0;
   int m_start, m_idle_from, m_cnt, m_cause;
   bit m_locked, m_prev;
   bit exp_sys, exp_fault;

   task automatic check(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, k);
   endtask

   task automatic model_reset();
      m_start = -100000; m_idle_from = 0; m_cnt = 0; m_cause = 0;
      m_locked = 1'b0; m_prev = 1'b0;
      exp_sys = 1'b0; exp_fault = 1'b0;
   endtask

   task automatic model_step(input bit tr, input bit s, input bit c);
      bit evt;
      evt = tr && !m_prev;
      m_prev = tr;
      if (m_locked) begin
         if (c) begin m_locked = 1'b0; m_cnt = 0; m_cause = 0; end
      end else if (k >= m_idle_from) begin
         if (evt) begin
            m_cnt++;
            if (m_cnt >= MAXR) begin
               m_locked = 1'b1; m_cause = 3;
            end else begin
               m_start = k; m_idle_from = k + P + G + 1; m_cause = 1;
            end
         end else if (s) begin
            m_start = k; m_idle_from = k + P + G + 1; m_cause = 2;
         end else if (c) begin
            m_cnt = 0; m_cause = 0;
         end
      end
      exp_sys   = m_locked || (k >= m_start && k < m_start + P);
      exp_fault = m_locked;
      k++;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle.
   task automatic step(input bit tr, input bit s, input bit c);
      trip = tr; sw = s; clr = c;
      @(posedge clk);
      if (rst_n) model_step(tr, s, c);
      else       model_reset();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      rst_n = 1'b1;
   endtask

   // Count sys_rst_o high cycles over n steps with a constant input pattern.
   task automatic count_hi(input int n, input bit tr, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         step(tr, 0, 0);
         if (sys_rst) hi++;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("sys_rst_o", int'(sys_rst), int'(exp_sys));
         check("wdt_kick_o", int'(kick), int'(exp_sys));
         check("fault_o", int'(fault), int'(exp_fault));
         check("reset_cnt_o", int'(cnt), m_cnt);
`ifdef WDT_CAUSE_EN
         check("cause_o", int'(cause), m_cause);
`endif
      end
   end

   initial begin
      int hi;
      model_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      check("reset sys_rst_o", int'(sys_rst), 0);
      check("reset fault_o", int'(fault), 0);
      check("reset reset_cnt_o", int'(cnt), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // A: held trip gives exactly one 16-cycle pulse.
      step(1, 0, 0);
      check("A first cycle high", int'(sys_rst), 1);
      count_hi(99, 1'b1, hi);
      check("A pulse length", hi + 1, 16);
      check("A count", int'(cnt), 1);
`ifdef WDT_CAUSE_EN
      check("A cause wdt", int'(cause), 1);
`endif
      step(0, 0, 1);
      check("A clr count", int'(cnt), 0);
`ifdef WDT_CAUSE_EN
      check("A clr cause", int'(cause), 0);
`endif

      // B: grace masking, re-trip, sw request, lockout, clear.
      do_reset();
      step(1, 0, 0);
      for (int i = 0; i < 25; i++) step(0, 0, 0);
      step(1, 0, 0);
      check("B grace trip ignored", int'(sys_rst), 0);
      step(0, 0, 0);
      check("B grace count", int'(cnt), 1);
      for (int i = 0; i < 58; i++) step(0, 0, 0);
      step(1, 0, 0);
      check("B retrip pulse", int'(sys_rst), 1);
      check("B retrip count", int'(cnt), 2);
      for (int i = 0; i < 90; i++) step(0, 0, 0);
      step(0, 1, 0);
      check("B sw pulse", int'(sys_rst), 1);
      check("B sw count", int'(cnt), 2);
`ifdef WDT_CAUSE_EN
      check("B sw cause", int'(cause), 2);
`endif
      count_hi(100, 1'b0, hi);
      check("B sw pulse length", hi + 1, 16);
      step(1, 1, 0);
      check("B lock fault", int'(fault), 1);
      check("B lock count", int'(cnt), 3);
`ifdef WDT_CAUSE_EN
      check("B lock cause", int'(cause), 3);
`endif
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      check("B locked holds", int'(sys_rst), 1);
      check("B locked count", int'(cnt), 3);
      step(0, 0, 1);
      check("B clr sys_rst_o", int'(sys_rst), 0);
      check("B clr fault_o", int'(fault), 0);
      check("B clr count", int'(cnt), 0);
`ifdef WDT_CAUSE_EN
      check("B clr cause", int'(cause), 0);
`endif

      // C: asynchronous reset in the middle of a pulse.
      step(1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("C async drop", int'(sys_rst), 0);
      step(0, 0, 0);
      step(0, 0, 0);
      rst_n = 1'b1;
      step(0, 0, 0);
      check("C count cleared", int'(cnt), 0);
      step(1, 0, 0);
      count_hi(99, 1'b1, hi);
      check("C full pulse", hi + 1, 16);

      // D: randomized traffic with occasional asynchronous resets.
      trip = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         bit tr;
         tr = trip;
         if ($urandom_range(0, 29) == 0) tr = ~tr;
         if ($urandom_range(0, 1999) == 0) begin
            rst_n = 1'b0;
            model_reset();
            step(tr, 0, 0);
            rst_n = 1'b1;
         end else begin
            step(tr, ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
         end
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
